// File: rtl/conv_window_scheduler_if.sv
// Bundles the image-memory read port and the output-pixel valid/ready stream
// of conv_window_scheduler; master is the scheduler side.
interface conv_window_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
);
  logic                  img_rd;
  logic [ADDR_WIDTH-1:0] img_addr;
  logic [DATA_WIDTH-1:0] img_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0]  out_row;
  logic [IDX_WIDTH-1:0]  out_col;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output img_rd, img_addr, out_data, out_row, out_col, out_valid,
    input  img_data, out_ready
  );

  modport slave (
    input  img_rd, img_addr, out_data, out_row, out_col, out_valid,
    output img_data, out_ready
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Walks a D x F x F window over an H x W feature map, feeding one convolution
// unit and streaming one pixel per window. Optional ReLU: CONV_SCHED_RELU_EN.
module conv_window_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int D          = 1,
  parameter int F          = 5,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  conv_window_scheduler_if.master      bus,
  output logic [D*F*F*DATA_WIDTH-1:0]  window,
  output logic                         conv_rst,
  input  logic [DATA_WIDTH-1:0]        conv_result,
  output logic                         busy,
  output logic                         done
);
  localparam int N  = D * F * F;
  localparam int OH = H - F + 1;
  localparam int OW = W - F + 1;
  localparam int CW = $clog2(N + 3);

  typedef enum logic [2:0] {IDLE, FETCH, CLR, CONV, CAP, OUT} stateType;

  stateType              state, nextState;
  logic [CW-1:0]         cnt, sIdx, rIdx, cIdx, wrIdx;
  logic                  rdPending;
  logic [IDX_WIDTH-1:0]  row, col;
  logic                  lastPixel, accept, readNow;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic [DATA_WIDTH-1:0] capValue;

  assign lastPixel = (row == IDX_WIDTH'(OH - 1)) && (col == IDX_WIDTH'(OW - 1));
  assign accept    = (state == OUT) && bus.out_ready;
  assign readNow   = (state == FETCH) && (cnt < CW'(N));
  assign fetchAddr = ADDR_WIDTH'(cIdx) * ADDR_WIDTH'(H * W)
                   + (ADDR_WIDTH'(row) + ADDR_WIDTH'(rIdx)) * ADDR_WIDTH'(W)
                   + ADDR_WIDTH'(col) + ADDR_WIDTH'(sIdx);

`ifdef CONV_SCHED_RELU_EN
  assign capValue = conv_result[DATA_WIDTH-1] ? '0 : conv_result;
`else
  assign capValue = conv_result;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // The unit is held in reset while idle and for the single CLR cycle.
  always_comb begin
    nextState     = state;
    conv_rst      = 1'b0;
    busy          = 1'b1;
    bus.out_valid = 1'b0;
    bus.img_rd    = readNow;
    bus.img_addr  = readNow ? fetchAddr : '0;
    case (state)
      IDLE: begin
        conv_rst = 1'b1;
        busy     = 1'b0;
        if (start) nextState = FETCH;
      end
      FETCH: if (cnt == CW'(N)) nextState = CLR;
      CLR: begin
        conv_rst  = 1'b1;
        nextState = CONV;
      end
      CONV: if (cnt == CW'(N + 1)) nextState = CAP;
      CAP:  nextState = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nextState = lastPixel ? IDLE : FETCH;
      end
      default: nextState = IDLE;
    endcase
  end

  // Read data lands one cycle after its strobe, so the element index is
  // delayed alongside the strobe before the window write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      sIdx         <= '0;
      rIdx         <= '0;
      cIdx         <= '0;
      wrIdx        <= '0;
      rdPending    <= 1'b0;
      window       <= '0;
      row          <= '0;
      col          <= '0;
      bus.out_data <= '0;
      bus.out_row  <= '0;
      bus.out_col  <= '0;
      done         <= 1'b0;
    end else begin
      rdPending <= readNow;
      wrIdx     <= cnt;
      done      <= accept && lastPixel;
      for (int k = 0; k < N; k++) begin
        if (rdPending && wrIdx == CW'(k)) window[k*DATA_WIDTH +: DATA_WIDTH] <= bus.img_data;
      end
      if (state != FETCH) begin
        sIdx <= '0;
        rIdx <= '0;
        cIdx <= '0;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            row <= '0;
            col <= '0;
          end
        end
        FETCH: begin
          cnt <= (cnt == CW'(N)) ? '0 : cnt + CW'(1);
          if (readNow) begin
            if (sIdx == CW'(F - 1)) begin
              sIdx <= '0;
              if (rIdx == CW'(F - 1)) begin
                rIdx <= '0;
                cIdx <= cIdx + CW'(1);
              end else begin
                rIdx <= rIdx + CW'(1);
              end
            end else begin
              sIdx <= sIdx + CW'(1);
            end
          end
        end
        CLR:  cnt <= '0;
        CONV: cnt <= cnt + CW'(1);
        CAP: begin
          cnt          <= '0;
          bus.out_data <= capValue;
          bus.out_row  <= row;
          bus.out_col  <= col;
        end
        OUT: begin
          cnt <= '0;
          if (accept && !lastPixel) begin
            if (col == IDX_WIDTH'(OW - 1)) begin
              col <= '0;
              row <= row + IDX_WIDTH'(1);
            end else begin
              col <= col + IDX_WIDTH'(1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule
